// File: rtl/patient_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// patient_dispatcher_pkg
//
// Shared definitions for the patient dispatcher slice:
//   - FSM state encoding of the allocator handshake
//   - allocator reply codes (message input) and patient category codes
//   - queue entry layout {category, token}
//   - field widths used by the dispatcher and its queue
// -----------------------------------------------------------------------------
package patient_dispatcher_pkg;

   // Token is a free-running 4-bit ticket number; occupancy needs one extra
   // bit so that a full 16-deep queue can report 16.
   localparam int TOKEN_W = 4;
   localparam int COUNT_W = 5;

   // Allocator handshake states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_PULSE   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_SAMPLE  = 3'd4,
      ST_BACKOFF = 3'd5
   } state_t;

   // Allocator reply codes seen on the message input.
   localparam logic [1:0] MSG_NONE = 2'b00;
   localparam logic [1:0] MSG_A    = 2'b01;
   localparam logic [1:0] MSG_B    = 2'b10;
   localparam logic [1:0] MSG_BUSY = 2'b11;

   // Patient category codes carried in the queue and presented on query.
   localparam logic [1:0] QRY_NONE      = 2'b00;
   localparam logic [1:0] QRY_GENERAL   = 2'b01;
   localparam logic [1:0] QRY_SURGICAL  = 2'b10;
   localparam logic [1:0] QRY_EMERGENCY = 2'b11;

   // One waiting patient.
   typedef struct packed {
      logic [1:0]         query;
      logic [TOKEN_W-1:0] token;
   } patient_t;

   // A reply grants a doctor only when it names doctor A or doctor B;
   // "busy" and "no reply" both mean try again later.
   function automatic logic is_grant(input logic [1:0] msg);
      return (msg == MSG_A) || (msg == MSG_B);
   endfunction

endpackage

// File: rtl/patient_fifo.sv
// -----------------------------------------------------------------------------
// patient_fifo
//
// Circular queue of waiting patients. The head entry is visible
// combinationally on rdata so the dispatcher can present its category and
// capture its token without an extra read cycle.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset (clears pointers and occupancy)
//   push   write wdata at the tail; ignored when full unless pop is also high
//   pop    drop the head entry; ignored when empty
//   wdata  entry to enqueue
//   rdata  current head entry (meaningless while empty)
//   count  occupancy, 0..DEPTH
//   full   count == DEPTH
//   empty  count == 0
// -----------------------------------------------------------------------------
module patient_fifo
   import patient_dispatcher_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  patient_t           wdata,
   output patient_t           rdata,
   output logic [COUNT_W-1:0] count,
   output logic               full,
   output logic               empty
);

   // DEPTH is a power of two, so the pointers wrap on their own.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   patient_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == COUNT_W'(DEPTH));
   assign empty = (count == '0);

   // A push into a full queue is still accepted when the head leaves on the
   // same edge: the freed slot is the one the tail pointer already addresses.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign rdata = mem[rd_ptr];

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         // Simultaneous push and pop leaves occupancy unchanged.
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // NOTE: storage has no reset; the pointers and count alone decide which
   // entries are valid, so clearing the array would only cost logic.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/patient_dispatcher.sv
// -----------------------------------------------------------------------------
// patient_dispatcher
//
// Queues arriving patients and hands them, strictly in arrival order, to an
// external doctor allocator. For the head patient the dispatcher presents the
// category on query, raises start for one cycle (the allocator acts on its
// falling edge), and samples the reply two cycles after the pulse. A grant
// (doctor A or B) retires the head and reports the assignment; a busy reply
// or no reply waits BACKOFF idle cycles and retries the same head.
//
// Parameters
//   DEPTH    waiting-queue depth, power of two, 2..16
//   BACKOFF  idle cycles between a refused reply and the retry, 1..15
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   new_patient      enqueue strobe, sampled every rising edge
//   new_query        category of the patient being enqueued
//   message          allocator reply: 01 doctor A, 10 doctor B, 11 busy, 00 none
//   query            category presented to the allocator
//   start            allocator strobe, high only during the PULSE state
//   assigned_valid   one-cycle pulse per completed assignment
//   assigned_doctor  granted doctor code, valid with assigned_valid
//   assigned_token   token of the assigned patient, valid with assigned_valid
//   drop             one-cycle pulse the cycle after a refused enqueue
//   count            current queue occupancy
//   full / empty     count == DEPTH / count == 0
// -----------------------------------------------------------------------------
module patient_dispatcher
   import patient_dispatcher_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int BACKOFF = 4
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               new_patient,
   input  logic [1:0]         new_query,
   input  logic [1:0]         message,
   output logic [1:0]         query,
   output logic               start,
   output logic               assigned_valid,
   output logic [1:0]         assigned_doctor,
   output logic [TOKEN_W-1:0] assigned_token,
   output logic               drop,
   output logic [COUNT_W-1:0] count,
   output logic               full,
   output logic               empty
);

   // The backoff counter is loaded with BACKOFF-1 on entry and the state is
   // left when it reads zero, giving exactly BACKOFF cycles in ST_BACKOFF.
   localparam logic [3:0] BACKOFF_LOAD = 4'(BACKOFF - 1);

   state_t             state;
   logic [3:0]         backoff_cnt;
   logic [TOKEN_W-1:0] next_token;
   patient_t           head;
   patient_t           tail_entry;
   logic               pop_head;
   logic               accept;

   // ---------------------------------------------------------------------------
   // Queue
   // ---------------------------------------------------------------------------
   // The head is retired on the same edge that leaves SAMPLE with a grant, so
   // the pop strobe is decoded straight from the current state and reply.
   assign pop_head = (state == ST_SAMPLE) && is_grant(message);

   // Mirrors the queue's own acceptance rule; needed here to advance the
   // token counter and to flag refused arrivals.
   assign accept = new_patient && (!full || pop_head);

   assign tail_entry = '{query: new_query, token: next_token};

   patient_fifo #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (new_patient),
      .pop   (pop_head),
      .wdata (tail_entry),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // ---------------------------------------------------------------------------
   // Token counter and refusal flag
   // ---------------------------------------------------------------------------
   // Tokens are handed out only to accepted patients, so a refused arrival
   // does not burn a number; the counter wraps 15 -> 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         next_token <= '0;
         drop       <= 1'b0;
      end else begin
         if (accept) next_token <= next_token + 1'b1;
         drop <= new_patient && !accept;
      end
   end

   // ---------------------------------------------------------------------------
   // Allocator handshake FSM with registered outputs
   // ---------------------------------------------------------------------------
   // query is loaded from the head on every entry into SETUP and then held,
   // so it is stable across SETUP..SAMPLE. start is set only on the edge that
   // enters PULSE and cleared on the edge that leaves it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         query           <= QRY_NONE;
         start           <= 1'b0;
         assigned_valid  <= 1'b0;
         assigned_doctor <= MSG_NONE;
         assigned_token  <= '0;
         backoff_cnt     <= '0;
      end else begin
         // Assignment report is a single-cycle pulse.
         assigned_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  query <= head.query;
                  state <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               start <= 1'b1;
               state <= ST_PULSE;
            end

            ST_PULSE: begin
               // Falling edge of start: the allocator acts on this.
               start <= 1'b0;
               state <= ST_RELEASE;
            end

            ST_RELEASE: begin
               state <= ST_SAMPLE;
            end

            ST_SAMPLE: begin
               if (is_grant(message)) begin
                  assigned_valid  <= 1'b1;
                  assigned_doctor <= message;
                  assigned_token  <= head.token;
                  state           <= ST_IDLE;
               end else begin
                  // Busy or silent allocator: keep the head (no bypass of
                  // later arrivals) and retry after the backoff interval.
                  backoff_cnt <= BACKOFF_LOAD;
                  state       <= ST_BACKOFF;
               end
            end

            ST_BACKOFF: begin
               if (backoff_cnt == '0) begin
                  query <= head.query;
                  state <= ST_SETUP;
               end else begin
                  backoff_cnt <= backoff_cnt - 1'b1;
               end
            end

            default: begin
               start <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/patient_dispatcher.md
PATIENT_DISPATCHER -- requirements
Module: patient_dispatcher

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the waiting-patient queue depth (power of two, 2..16).
REQ-002 Parameter BACKOFF, default 4, SHALL set the idle cycles between a busy reply and the retry (1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 new_patient  input  1  SHALL be the enqueue strobe, sampled each rising edge.
REQ-006 new_query  input  2  SHALL be the patient category enqueued with new_patient.
REQ-007 message  input  2  SHALL be the allocator reply: 01 doctor A, 10 doctor B, 11 busy, 00 no reply.
REQ-008 query  output  2  SHALL be the category presented to the allocator.
REQ-009 start  output  1  SHALL be the allocator strobe; its falling edge triggers allocation.
REQ-010 assigned_valid  output  1  SHALL pulse one cycle per completed assignment.
REQ-011 assigned_doctor  output  2  SHALL be the granted doctor code (01/10), valid with assigned_valid.
REQ-012 assigned_token  output  4  SHALL be the token of the assigned patient, valid with assigned_valid.
REQ-013 drop  output  1  SHALL pulse one cycle when an enqueue is refused.
REQ-014 count  output  5  SHALL be the current queue occupancy.
REQ-015 full / empty  output  1 each  SHALL flag count==DEPTH / count==0.

Function
REQ-016 Accepted enqueue SHALL store {new_query, token} at the tail; token SHALL be a 4-bit counter incremented per accepted enqueue, wrapping 15->0.
REQ-017 Enqueue while full SHALL be refused: queue and token counter unchanged, drop high the following cycle.
REQ-018 Enqueue on the cycle the head is popped while full SHALL be accepted.
REQ-019 FSM states SHALL be IDLE, SETUP, PULSE, RELEASE, SAMPLE, BACKOFF.
REQ-020 IDLE -> SETUP when the queue is non-empty; otherwise remain in IDLE.
REQ-021 SETUP: query driven from the head entry, start=0; -> PULSE.
REQ-022 PULSE: start=1, query held; -> RELEASE.
REQ-023 RELEASE: start=0 (falling edge), query held; -> SAMPLE.
REQ-024 SAMPLE: message 01 or 10 SHALL pop the head, register assigned_valid=1, assigned_doctor=message and assigned_token=head token for the next cycle only, then -> IDLE.
REQ-025 SAMPLE: message 11 or 00 SHALL leave the head in place (strict FIFO order, no bypass) and -> BACKOFF.
REQ-026 BACKOFF SHALL last exactly BACKOFF cycles, then -> SETUP to retry the same head.
REQ-027 query SHALL be stable from SETUP through SAMPLE; start SHALL never be high outside PULSE.
REQ-028 Head to assigned_valid latency SHALL be 5 cycles from leaving IDLE (SETUP, PULSE, RELEASE, SAMPLE, output).
REQ-029 count SHALL equal accepted enqueues minus pops; simultaneous enqueue and pop SHALL leave count unchanged.
REQ-030 Enqueues SHALL be accepted in every FSM state.

Reset
REQ-031 rst SHALL immediately force start=0, query=00, assigned_valid=0, assigned_doctor=00, assigned_token=0, drop=0, count=0, empty=1, full=0, FSM=IDLE.
REQ-032 rst SHALL clear the queue pointers and token counter to 0; reset mid-handshake SHALL abandon the patient without any further start edge.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, message codes (MSG_NONE, MSG_A, MSG_B, MSG_BUSY) and query codes.
REQ-034 Queue storage SHALL be one sub-module, patient_fifo (push, pop, data, count, full, empty).
REQ-035 The FSM, token counter, backoff counter and output registers SHALL reside in patient_dispatcher.

Verification
REQ-036 Reset, enqueue query 01 once, message=01 in SAMPLE -> single start pulse, assigned_valid 5 cycles after leaving IDLE, doctor 01, token 0, count back to 0.
REQ-037 message=11 twice, then 10 -> three start pulses, each retry preceded by exactly 4 BACKOFF cycles, final assigned_doctor 10, token unchanged.
REQ-038 Five back-to-back enqueues, no pops, DEPTH=4 -> full after fourth, drop on fifth, count 4, tokens 0..3 stored.
REQ-039 Full queue, enqueue coincident with SAMPLE pop on message 01 -> enqueue accepted, count stays 4, no drop.
REQ-040 17 patients served in order -> tokens 0..15 then 0, assignments in arrival order.
REQ-041 Assert rst during PULSE -> start low immediately, count 0, no assigned_valid, FSM IDLE after release.
